// File: rtl/alu_arbiter_if.sv
// Request/response bundle for alu_arbiter. slave is the arbiter side,
// master is the requester side.
interface alu_arbiter_if #(
  parameter int unsigned l = 16,
  parameter int unsigned p = 0
);
  logic [1:0]           ReqValid;
  logic [1:0]           ReqReady;
  logic [2*(p+1)-1:0]   ReqOperation;
  logic [2*l-1:0]       ReqA;
  logic [2*l-1:0]       ReqB;
  logic [1:0]           RespValid;
  logic [1:0]           RespReady;
  logic [l-1:0]         RespR;
  logic [l-1:0]         RespFlags;
  logic [1:0]           FlagsClear;
  logic                 Busy;

  modport slave (
    input  ReqValid, ReqOperation, ReqA, ReqB, RespReady, FlagsClear,
    output ReqReady, RespValid, RespR, RespFlags, Busy
  );

  modport master (
    output ReqValid, ReqOperation, ReqA, ReqB, RespReady, FlagsClear,
    input  ReqReady, RespValid, RespR, RespFlags, Busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared signed mul/div ALU.
// Operands are latched at the request handshake and held on the ALU for
// Latency cycles; the result and the requester's private flags context are
// then returned over a per-requester valid/ready response channel.
// Opcodes: 0 = signed divide (truncating), 1 = signed multiply (low word),
// anything else returns A and leaves flags untouched.
// Flag bits: 0 MultiplicationOverflow, 1 DivisionByZero, 2 DivisionHasRemainder.
// Define ALU_ARB_B2B_EN to let a response handshake and the next request
// grant happen in the same cycle.
module alu_arbiter #(
  parameter int unsigned l       = 16,
  parameter int unsigned p       = 0,
  parameter int unsigned Latency = 2
) (
  input logic          Clock,
  input logic          ResetN,
  alu_arbiter_if.slave bus
);

  localparam int unsigned FlagMulOvf  = 0;
  localparam int unsigned FlagDivZero = 1;
  localparam int unsigned FlagDivRem  = 2;

  localparam logic [p:0] OpDiv = '0;
  localparam logic [p:0] OpMul = (p+1)'(1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} arbState;

  arbState        stateQ;
  logic           gQ;
  logic           ptrQ;
  logic [3:0]     cntQ;
  logic [p:0]     opQ;
  logic [l-1:0]   aQ;
  logic [l-1:0]   bQ;
  logic [l-1:0]   respRQ;
  logic [l-1:0]   respFlagsQ;
  logic [1:0]     respValidQ;
  logic [l-1:0]   ctxQ [2];

  logic           canGrant;
  logic           grant;
  logic           reqFire;
  logic [1:0]     reqReady;
  logic [p:0]     grantOp;
  logic [l-1:0]   grantA;
  logic [l-1:0]   grantB;

  logic signed [2*l-1:0] aExt;
  logic signed [2*l-1:0] bExt;
  logic signed [2*l-1:0] divisor;
  logic signed [2*l-1:0] rem;
  logic signed [2*l-1:0] prod;
  logic [l-1:0]          aluR;
  logic [l-1:0]          aluFlags;

  // Grant selection: rr pointer breaks ties, a lone requester always wins.
  always_comb begin
    canGrant = ResetN && (stateQ == StIdle);
`ifdef ALU_ARB_B2B_EN
    // Response handshake frees the ALU in the same cycle.
    if (stateQ == StResp && bus.RespReady[gQ]) begin
      canGrant = ResetN;
    end
`endif
    if (&bus.ReqValid) begin
      grant = ptrQ;
    end else begin
      grant = bus.ReqValid[1];
    end
    reqFire  = canGrant && (|bus.ReqValid);
    reqReady = '0;
    if (reqFire) begin
      reqReady[grant] = 1'b1;
    end
    grantOp = grant ? bus.ReqOperation[2*(p+1)-1:p+1] : bus.ReqOperation[p:0];
    grantA  = grant ? bus.ReqA[2*l-1:l] : bus.ReqA[l-1:0];
    grantB  = grant ? bus.ReqB[2*l-1:l] : bus.ReqB[l-1:0];
  end

  // Shared ALU, fed only from latched operands and the owner's flags context.
  always_comb begin
    aExt     = {{l{aQ[l-1]}}, aQ};
    bExt     = {{l{bQ[l-1]}}, bQ};
    // Double-width operands keep MIN / -1 and the full product exact.
    divisor  = (bQ == '0) ? (2*l)'(1) : bExt;
    rem      = aExt % divisor;
    prod     = aExt * bExt;
    aluR     = aQ;
    aluFlags = ctxQ[gQ];
    case (opQ)
      OpDiv: begin
        aluR                  = (bQ == '0) ? '0 : l'(aExt / divisor);
        aluFlags[FlagDivZero] = (bQ == '0);
        aluFlags[FlagDivRem]  = (bQ != '0) && (rem != '0);
      end
      OpMul: begin
        aluR                 = prod[l-1:0];
        aluFlags[FlagMulOvf] = (prod != {{l{prod[l-1]}}, prod[l-1:0]});
      end
      default: ;
    endcase
  end

  // Sequencer: IDLE -> EXEC (settle window) -> RESP, plus per-requester flag contexts.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      stateQ     <= StIdle;
      gQ         <= 1'b0;
      ptrQ       <= 1'b0;
      cntQ       <= '0;
      opQ        <= '0;
      aQ         <= '0;
      bQ         <= '0;
      respRQ     <= '0;
      respFlagsQ <= '0;
      respValidQ <= '0;
      ctxQ[0]    <= '0;
      ctxQ[1]    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus.FlagsClear[i]) begin
          ctxQ[i] <= '0;
        end
      end
      unique case (stateQ)
        StIdle: ;
        StExec: begin
          if (cntQ == '0) begin
            respRQ          <= aluR;
            respFlagsQ      <= aluFlags;
            // Written after the clear loop so a coincident capture wins.
            ctxQ[gQ]        <= aluFlags;
            respValidQ[gQ]  <= 1'b1;
            stateQ          <= StResp;
          end else begin
            cntQ <= cntQ - 1'b1;
          end
        end
        StResp: begin
          if (bus.RespReady[gQ]) begin
            respValidQ <= '0;
            stateQ     <= StIdle;
          end
        end
        default: stateQ <= StIdle;
      endcase
      // A new grant overrides the RESP -> IDLE step when back-to-back is on.
      if (reqFire) begin
        opQ    <= grantOp;
        aQ     <= grantA;
        bQ     <= grantB;
        gQ     <= grant;
        ptrQ   <= ~grant;
        cntQ   <= 4'(Latency - 1);
        stateQ <= StExec;
      end
    end
  end

  assign bus.ReqReady  = reqReady;
  assign bus.RespValid = respValidQ;
  assign bus.RespR     = respRQ;
  assign bus.RespFlags = respFlagsQ;
  assign bus.Busy      = (stateQ != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
  localparam int L   = 16;
  localparam int P   = 0;
  localparam int Lat = 2;
`ifdef ALU_ARB_B2B_EN
  localparam int Gap = 0;
  localparam bit B2B = 1'b1;
`else
  localparam int Gap = 1;
  localparam bit B2B = 1'b0;
`endif

  logic Clock = 1'b0;
  logic ResetN = 1'b0;

  alu_arbiter_if #(.l(L), .p(P)) bus();

  alu_arbiter #(.l(L), .p(P), .Latency(Lat)) dut (
    .Clock (Clock),
    .ResetN(ResetN),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int          who;
    logic [15:0] r;
    logic [15:0] f;
    int          hsCyc;
  } expT;

  // Model state, owned by the monitor.
  expT         q[$];
  logic [15:0] ctx [2];
  int          ptr;
  int          hsCount [2];
  int          nChecks;
  int          nPass;
  int          streamIdx;
  int          lastRespHs;
  int          prevPhase;
  bit          endDone;

  // Driver state, owned by the main initial block.
  int phase;
  bit keepValid;
  bit endReq;
  int tmo;
  int seen [2];
  bit accepted [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got === want) nPass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
  endtask

  // Reference ALU from the arithmetic rules, using plain int arithmetic.
  function automatic void refAlu(input int op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] fin, output logic [15:0] r,
                                 output logic [15:0] fout);
    int as, bs, qt, pr;
    as   = int'($signed(a));
    bs   = int'($signed(b));
    fout = fin;
    r    = a;
    if (op == 0) begin
      fout[1] = (bs == 0);
      if (bs == 0) begin
        r       = 16'h0;
        fout[2] = 1'b0;
      end else begin
        qt      = as / bs;
        r       = qt[15:0];
        fout[2] = (as % bs) != 0;
      end
    end else begin
      pr      = as * bs;
      r       = pr[15:0];
      fout[0] = (pr > 32767) || (pr < -32768);
    end
  endfunction

  // Monitor: sampled on the falling edge, mirrors each handshake into the model.
  always @(negedge Clock) begin
    bit          inFl, respHs, canGrant;
    logic [1:0]  wantRv, wantRdy;
    int          g;
    logic [15:0] r, f;
    if (!ResetN) begin
      check("rstRespValid", 32'(bus.RespValid), 32'h0);
      check("rstBusy", 32'(bus.Busy), 32'h0);
      check("rstReqReady", 32'(bus.ReqReady), 32'h0);
      q.delete();
      ctx[0] = '0;
      ctx[1] = '0;
      ptr    = 0;
    end else begin
      inFl   = q.size() > 0;
      wantRv = '0;
      if (inFl && cyc >= q[0].hsCyc + Lat + 1) wantRv = 2'(1 << q[0].who);
      check("respValid", 32'(bus.RespValid), 32'(wantRv));
      check("busy", 32'(bus.Busy), 32'(inFl));
      respHs = 1'b0;
      if (wantRv != 0) begin
        check("respR", 32'(bus.RespR), 32'(q[0].r));
        check("respFlags", 32'(bus.RespFlags), 32'(q[0].f));
        if (bus.RespReady[q[0].who]) begin
          respHs     = 1'b1;
          lastRespHs = cyc;
          void'(q.pop_front());
        end
      end
      for (int i = 0; i < 2; i++) if (bus.FlagsClear[i]) ctx[i] = '0;
      canGrant = !inFl || (B2B && respHs);
      if (bus.ReqValid == 2'b11) g = ptr;
      else g = bus.ReqValid[1] ? 1 : 0;
      wantRdy = (canGrant && bus.ReqValid != 0) ? 2'(1 << g) : 2'b00;
      check("reqReady", 32'(bus.ReqReady), 32'(wantRdy));
      if (phase == 1 && prevPhase != 1) streamIdx = 0;
      if (wantRdy != 0) begin
        refAlu(int'(bus.ReqOperation[g*(P+1) +: P+1]), bus.ReqA[g*L +: L], bus.ReqB[g*L +: L],
               ctx[g], r, f);
        ctx[g] = f;
        q.push_back('{who: g, r: r, f: f, hsCyc: cyc});
        ptr = 1 - g;
        hsCount[g]++;
        if (phase == 1) begin
          check("rrOrder", 32'(g), 32'(streamIdx % 2));
          if (streamIdx > 0) check("grantGap", 32'(cyc), 32'(lastRespHs + Gap));
          streamIdx++;
        end
      end
    end
    prevPhase = phase;
    if (endReq && !endDone) begin
      check("timeouts", 32'(tmo), 32'h0);
      check("queueDrained", 32'(q.size()), 32'h0);
      endDone = 1'b1;
    end
  end

  function automatic logic [15:0] randVal();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'($urandom_range(0, 9));
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      4:       return 16'($urandom_range(0, 400));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic setOp(input int i, input int op, input logic [15:0] a, input logic [15:0] b);
    bus.ReqOperation[i*(P+1) +: P+1] = (P+1)'(op);
    bus.ReqA[i*L +: L] = a;
    bus.ReqB[i*L +: L] = b;
  endtask

  task automatic randOp(input int i);
    setOp(i, int'($urandom_range(0, 1)), randVal(), randVal());
    bus.ReqValid[i] = 1'b1;
  endtask

  // One clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      accepted[i] = 1'b0;
      if (hsCount[i] != seen[i]) begin
        seen[i]     = hsCount[i];
        accepted[i] = 1'b1;
        if (keepValid) randOp(i);
        else bus.ReqValid[i] = 1'b0;
      end
    end
  endtask

  task automatic sendOp(input int i, input int op, input logic [15:0] a, input logic [15:0] b);
    setOp(i, op, a, b);
    bus.ReqValid[i] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (accepted[i]) break;
    end
    if (!accepted[i]) begin
      tmo++;
      bus.ReqValid[i] = 1'b0;
    end
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 200; k++) begin
      tick();
      if (q.size() == 0 && bus.ReqValid == 2'b00) break;
    end
    if (q.size() != 0 || bus.ReqValid != 2'b00) tmo++;
    tick();
  endtask

  initial begin
    int acc;
    bus.ReqValid     = '0;
    bus.ReqOperation = '0;
    bus.ReqA         = '0;
    bus.ReqB         = '0;
    bus.RespReady    = '0;
    bus.FlagsClear   = '0;
    repeat (3) tick();
    ResetN = 1'b1;
    bus.RespReady = 2'b11;
    tick();

    // Directed: divide, multiply overflow, flag persistence, clear.
    sendOp(0, 0, 16'hFFF9, 16'h0002);  waitIdle();
    sendOp(1, 1, 16'd300, 16'd300);    waitIdle();
    sendOp(0, 0, 16'd8, 16'd4);        waitIdle();
    sendOp(1, 0, 16'd5, 16'd0);        waitIdle();
    sendOp(1, 0, 16'd6, 16'd3);        waitIdle();
    bus.FlagsClear = 2'b10;
    tick();
    bus.FlagsClear = 2'b00;
    sendOp(1, 0, 16'd6, 16'd4);        waitIdle();
    sendOp(1, 0, 16'h8000, 16'hFFFF);  waitIdle();

    // Response held off: result must stay put and no second grant may occur.
    bus.RespReady = 2'b00;
    sendOp(0, 1, 16'hFFFD, 16'd1234);
    setOp(1, 0, 16'd100, 16'd7);
    bus.ReqValid[1] = 1'b1;
    repeat (Lat + 6) tick();
    bus.RespReady = 2'b11;
    waitIdle();

    // Reset while an operation is executing.
    sendOp(0, 1, 16'd300, 16'd300);
    ResetN = 1'b0;
    tick();
    tick();
    ResetN = 1'b1;
    tick();

    // Saturated stream from a fresh rr pointer.
    phase     = 1;
    keepValid = 1'b1;
    randOp(0);
    randOp(1);
    acc = 0;
    for (int k = 0; k < 300 && acc < 8; k++) begin
      tick();
      acc += int'(accepted[0]) + int'(accepted[1]);
    end
    if (acc < 8) tmo++;
    keepValid    = 1'b0;
    bus.ReqValid = 2'b00;
    waitIdle();
    phase = 0;
    tick();

    // Random traffic with back-pressure, drops and clears.
    phase = 2;
    for (int n = 0; n < 800; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (!bus.ReqValid[i] && $urandom_range(0, 2) == 0) randOp(i);
        else if (bus.ReqValid[i] && $urandom_range(0, 15) == 0) bus.ReqValid[i] = 1'b0;
      end
      bus.RespReady  = 2'($urandom_range(0, 3));
      bus.FlagsClear = 2'b00;
      if (q.size() == 0 && $urandom_range(0, 9) == 0) bus.FlagsClear[$urandom_range(0, 1)] = 1'b1;
    end
    bus.ReqValid   = 2'b00;
    bus.FlagsClear = 2'b00;
    bus.RespReady  = 2'b11;
    waitIdle();
    phase  = 0;
    endReq = 1'b1;
    tick();
    tick();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", nPass, nChecks);
    $fatal(1);
  end

endmodule
